cpu: RTL and testbench

//   Minimal single-cycle 4-register CPU executing a fixed program from an internal ROM.

---
 rtl/cpu_if.sv | 18 +
 rtl/cpu.sv | 100 ++++++++++
 tb/tb_cpu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_if.sv
// Board-facing signals of the demo CPU: user switch in, R1 value out.
// The core takes the slave side; the board or bench takes the master side.
interface cpu_if #(
  parameter int W = 8
);
  logic         switch;
  logic [W-1:0] register1Value;

  modport master (
    output switch,
    input  register1Value
  );

  modport slave (
    input  switch,
    output register1Value
  );
endinterface

// File: rtl/cpu.sv
// Single-cycle 4-register CPU running a fixed program from an internal ROM.
// Word 0 of ROM_IMAGE sits in the low 16 bits; unlisted words are NOP.
module cpu #(
  parameter int REGISTER_WIDTH = 8,
  parameter int PC_WIDTH       = 5,
  parameter logic [(2**PC_WIDTH)*16-1:0] ROM_IMAGE = {
    {((2**PC_WIDTH)-5)*16{1'b0}},
    80'h5001_8400_5001_7003_1400
  }
) (
  input  logic clock,
  input  logic isReset,
  cpu_if.slave io
);

  localparam int W = REGISTER_WIDTH;
  typedef logic [W-1:0] word_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JSW  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [3:0][W-1:0]   regs, regs_nxt;
  logic                halted, halted_nxt;
  logic                sw_meta, sw_sync;

  logic [15:0]         instr;
  logic [3:0]          op;
  logic [1:0]          rd, rs;
  logic [7:0]          imm;
  word_t               a, b, immw;
  logic [PC_WIDTH-1:0] tgt;

  assign instr = ROM_IMAGE[{pc, 4'b0000} +: 16];
  assign op    = instr[15:12];
  assign rd    = instr[11:10];
  assign rs    = instr[9:8];
  assign imm   = instr[7:0];
  assign immw  = word_t'(imm);
  assign tgt   = imm[PC_WIDTH-1:0];
  assign a     = regs[rd];
  assign b     = regs[rs];

  assign io.register1Value = regs[1];

  always_comb begin
    pc_nxt     = pc + 1'b1;
    regs_nxt   = regs;
    halted_nxt = halted;
    if (halted) begin
      pc_nxt = pc;
    end else begin
      unique case (1'b1)
        op == OP_LDI: regs_nxt[rd] = immw;
        op == OP_ADD: regs_nxt[rd] = a + b;
        op == OP_SUB: regs_nxt[rd] = a - b;
        op == OP_MOV: regs_nxt[rd] = b;
        op == OP_JMP: pc_nxt = tgt;
        op == OP_JZ: begin
          if (a == '0) pc_nxt = tgt;
        end
        op == OP_JSW: begin
          if (sw_sync) pc_nxt = tgt;
        end
        op == OP_INC: regs_nxt[rd] = a + 1'b1;
        op == OP_DEC: regs_nxt[rd] = a - 1'b1;
        op == OP_HALT: begin
          halted_nxt = 1'b1;
          pc_nxt     = pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      pc      <= '0;
      regs    <= '0;
      halted  <= 1'b0;
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      regs    <= regs_nxt;
      halted  <= halted_nxt;
      sw_meta <= io.switch;
      sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: three cores (default, ISA-test and mixed ROMs) checked
// every cycle against an instruction-level interpreter, plus directed cases.
`timescale 1ns/100ps
module tb_cpu;

  localparam logic [511:0] DEF_ROM = {
    432'h0,
    80'h5001_8400_5001_7003_1400
  };

  localparam logic [511:0] ISA_ROM = {
    416'h0,
    96'hF000_2500_4600_3B00_1C03_1805
  };

  localparam logic [511:0] MIX_ROM = {
    64'h3700_8C00_0000_0000,
    128'h0,
    64'h0000_0000_501E_8400,
    64'h500D_3700_7010_E123,
    64'h5008_680C_9800_2600,
    64'h1803_F000_14AA_6407,
    64'h8400_4400_9000_1000
  };

  logic clock   = 1'b0;
  logic isReset = 1'b0;
  logic sw      = 1'b0;
  bit   chk_en  = 1'b0;

  always #5 clock = ~clock;

  cpu_if #(.W(8)) ifa ();
  cpu_if #(.W(8)) ifb ();
  cpu_if #(.W(8)) ifc ();

  assign ifa.switch = sw;
  assign ifb.switch = sw;
  assign ifc.switch = sw;

  cpu #(.REGISTER_WIDTH(8), .PC_WIDTH(5)) u_def (
    .clock(clock), .isReset(isReset), .io(ifa)
  );
  cpu #(.REGISTER_WIDTH(8), .PC_WIDTH(5), .ROM_IMAGE(ISA_ROM)) u_isa (
    .clock(clock), .isReset(isReset), .io(ifb)
  );
  cpu #(.REGISTER_WIDTH(8), .PC_WIDTH(5), .ROM_IMAGE(MIX_ROM)) u_mix (
    .clock(clock), .isReset(isReset), .io(ifc)
  );

  // Interpreter state: one set per core
  logic [15:0] mrom [3][32];
  int          mreg [3][4];
  int          mpc  [3];
  bit          mhalt[3];
  bit          hist0, hist1;

  int passed = 0;
  int total  = 0;
  bit saw_wrap = 1'b0;
  int prev_a = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mpc[d]   = 0;
      mhalt[d] = 1'b0;
      for (int r = 0; r < 4; r++) mreg[d][r] = 0;
    end
    hist0 = 1'b0;
    hist1 = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] ins;
    int rd, rs, nxt;
    for (int d = 0; d < 3; d++) begin
      if (!mhalt[d]) begin
        ins = mrom[d][mpc[d]];
        rd  = int'(ins[11:10]);
        rs  = int'(ins[9:8]);
        nxt = (mpc[d] + 1) % 32;
        case (ins[15:12])
          4'h1: mreg[d][rd] = int'(ins[7:0]);
          4'h2: mreg[d][rd] = (mreg[d][rd] + mreg[d][rs]) % 256;
          4'h3: mreg[d][rd] = (mreg[d][rd] - mreg[d][rs] + 256) % 256;
          4'h4: mreg[d][rd] = mreg[d][rs];
          4'h5: nxt = int'(ins[4:0]);
          4'h6: if (mreg[d][rd] == 0) nxt = int'(ins[4:0]);
          4'h7: if (hist1) nxt = int'(ins[4:0]);
          4'h8: mreg[d][rd] = (mreg[d][rd] + 1) % 256;
          4'h9: mreg[d][rd] = (mreg[d][rd] + 255) % 256;
          4'hF: begin
            mhalt[d] = 1'b1;
            nxt      = mpc[d];
          end
          default: ;
        endcase
        mpc[d] = nxt;
      end
    end
    hist1 = hist0;
    hist0 = sw;
  endtask

  always @(negedge isReset) model_reset();

  always @(posedge clock) if (isReset) model_step();

  always @(negedge clock) begin
    if (chk_en) begin
      chk("def_r1", int'(ifa.register1Value), mreg[0][1]);
      chk("isa_r1", int'(ifb.register1Value), mreg[1][1]);
      chk("mix_r1", int'(ifc.register1Value), mreg[2][1]);
      if (prev_a == 255 && int'(ifa.register1Value) == 0) saw_wrap = 1'b1;
      prev_a = int'(ifa.register1Value);
    end
  end

  typedef struct {
    string nm;
    int    cycles;
    bit    sw;
    int    lo;
    int    hi;
  } vec_t;

  vec_t tbl[3];
  int   frz;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mrom[0][i] = DEF_ROM[i*16 +: 16];
      mrom[1][i] = ISA_ROM[i*16 +: 16];
      mrom[2][i] = MIX_ROM[i*16 +: 16];
    end
    model_reset();

    tbl[0] = '{nm: "idle",  cycles: 100, sw: 1'b0, lo: 0,  hi: 0};
    tbl[1] = '{nm: "count", cycles: 32,  sw: 1'b1, lo: 9,  hi: 11};
    tbl[2] = '{nm: "hold",  cycles: 30,  sw: 1'b0, lo: 10, hi: 11};

    // Reset held with switch high
    isReset = 1'b0;
    sw      = 1'b1;
    chk_en  = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rst_def", int'(ifa.register1Value), 0);
    end

    @(negedge clock);
    sw      = 1'b0;
    isReset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      sw = tbl[i].sw;
      repeat (tbl[i].cycles) @(negedge clock);
      chk_rng(tbl[i].nm, int'(ifa.register1Value), tbl[i].lo, tbl[i].hi);
    end

    // Freeze after switch drops
    sw = 1'b1;
    repeat (12) @(negedge clock);
    sw = 1'b0;
    repeat (4) @(negedge clock);
    frz = mreg[0][1];
    repeat (20) @(negedge clock);
    chk("freeze", int'(ifa.register1Value), frz);

    // Long count through 255 -> 0
    sw = 1'b1;
    repeat (3 * 256 + 12) @(negedge clock);
    chk("wrap_seen", int'(saw_wrap), 1);

    chk("isa_halt", int'(ifb.register1Value), 4);

    // Random switch activity
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) sw = 1'($urandom_range(0, 1));
      @(negedge clock);
    end

    // Short async reset pulse between edges while counting
    sw = 1'b1;
    repeat (20) @(negedge clock);
    #2;
    isReset = 1'b0;
    #0.5;
    chk("arst_def", int'(ifa.register1Value), 0);
    chk("arst_isa", int'(ifb.register1Value), 0);
    chk("arst_mix", int'(ifc.register1Value), 0);
    #0.5;
    isReset = 1'b1;
    repeat (32) @(negedge clock);
    chk_rng("recount", int'(ifa.register1Value), 9, 11);
    repeat (60) @(negedge clock);
    chk("isa_rehalt", int'(ifb.register1Value), 4);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
